// File: rtl/slfifo_bus_driver_if.sv
// slfifo_bus_driver_if: FX3 Slave FIFO pad bus as seen from the write-side driver.
interface slfifo_bus_driver_if #(parameter int DATA_W = 32);
   logic              flaga, flagb;
   logic              slcs_, slwr_, slrd_, sloe_, pktend_;
   logic [DATA_W-1:0] fdata;
   logic [1:0]        faddr;
   modport master (input flaga, flagb, output fdata, faddr, slcs_, slwr_, slrd_, sloe_, pktend_);
   modport slave  (output flaga, flagb, input fdata, faddr, slcs_, slwr_, slrd_, sloe_, pktend_);
endinterface

// File: rtl/slfifo_bus_driver.sv
// slfifo_bus_driver: registers FX3 flags, forwards generator writes onto the Slave FIFO bus
// and commits partial DMA buffers with a one-cycle PKTEND after an idle timeout or on mode exit.
module slfifo_bus_driver #(
   parameter int         DATA_W       = 32,
   parameter int         PKT_WORDS    = 4096,
   parameter int         IDLE_TIMEOUT = 256,
   parameter logic [1:0] FIFO_ADDR    = 2'b00
) (
   input  logic               clk_100,
   input  logic               reset_,
   input  logic               stream_in_mode_selected,
   input  logic               slwr_in_,
   input  logic [DATA_W-1:0]  data_in,
   output logic               flaga_d,
   output logic               flagb_d,
   output logic [15:0]        word_cnt,
   output logic [15:0]        pkt_cnt,
   output logic               overrun,
   slfifo_bus_driver_if.master bus
);
   localparam int            IW       = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);
   localparam logic [15:0]   WC_LAST  = 16'(PKT_WORDS - 1);
   typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;
   state_t            state_q, state_d;
   logic              flaga_q, flagb_q, slwr_q, pktend_q, slcs_q, overrun_q, overrun_d;
   logic [DATA_W-1:0] fdata_q;
   logic [15:0]       word_cnt_q, word_cnt_d, pkt_cnt_q, pkt_cnt_d;
   logic [IW-1:0]     idle_q, idle_d;
   logic              wr, wrap, mode_fall, timeout;
   assign wr        = !slwr_in_;
   assign wrap      = wr && word_cnt_q == WC_LAST;
   // slcs_q is last cycle's inverted mode, so it doubles as the falling-edge reference
   assign mode_fall = !stream_in_mode_selected && !slcs_q;
   // >= rather than == so a flush deferred by flagb fires once the counter has saturated
   assign timeout   = !wr && idle_q >= IDLE_MAX - 1'b1 && flagb_q;
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      idle_d     = wr ? '0 : (idle_q == IDLE_MAX ? idle_q : idle_q + 1'b1);
      overrun_d  = overrun_q | (wr & ~flagb_q);
      if (state_q == FLUSH) begin
         state_d    = IDLE;
         word_cnt_d = '0;
         idle_d     = '0;
         pkt_cnt_d  = pkt_cnt_q + 1'b1;
      end else begin
         if (wr) begin
            word_cnt_d = wrap ? '0 : word_cnt_q + 1'b1;
            pkt_cnt_d  = wrap ? pkt_cnt_q + 1'b1 : pkt_cnt_q;
            state_d    = wrap ? IDLE : FILL;
         end
         if (state_q == FILL && !wrap) begin
            if (mode_fall && flagb_q) state_d = FLUSH;
            else if (mode_fall) begin
               state_d    = IDLE;
               word_cnt_d = '0;
               overrun_d  = 1'b1;
            end else if (timeout) state_d = FLUSH;
         end
      end
   end
   always_ff @(posedge clk_100) begin
      if (!reset_) begin
         state_q    <= IDLE;
         flaga_q    <= 1'b0;
         flagb_q    <= 1'b0;
         slwr_q     <= 1'b1;
         pktend_q   <= 1'b1;
         slcs_q     <= 1'b1;
         fdata_q    <= '0;
         word_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         idle_q     <= '0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         flaga_q    <= bus.flaga;
         flagb_q    <= bus.flagb;
         slwr_q     <= slwr_in_;
         pktend_q   <= state_q != FLUSH;
         slcs_q     <= !stream_in_mode_selected;
         fdata_q    <= wr ? data_in : fdata_q;
         word_cnt_q <= word_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         idle_q     <= idle_d;
         overrun_q  <= overrun_d;
      end
   end
   assign flaga_d     = flaga_q;
   assign flagb_d     = flagb_q;
   assign word_cnt    = word_cnt_q;
   assign pkt_cnt     = pkt_cnt_q;
   assign overrun     = overrun_q;
   assign bus.fdata   = fdata_q;
   assign bus.faddr   = FIFO_ADDR;
   assign bus.slcs_   = slcs_q;
   assign bus.slwr_   = slwr_q;
   assign bus.slrd_   = 1'b1;
   assign bus.sloe_   = 1'b1;
   assign bus.pktend_ = pktend_q;
endmodule

// File: tb/tb_slfifo_bus_driver.sv
// tb_slfifo_bus_driver: directed scenarios plus randomized traffic against a
// word/packet-counting reference model of the FX3 write-side driver.
module tb_slfifo_bus_driver;
   localparam int DW = 32, PKT = 4096, TO = 256;
   logic          clk = 0, rst_n = 0, mode = 0, wr_n = 1;
   logic [DW-1:0] din = '0;
   logic          flaga_d, flagb_d, overrun;
   logic [15:0]   word_cnt, pkt_cnt;
   int            checks = 0, errors = 0, cyc = 0;
   // reference model state
   int            m_buf, m_pkts, m_idle;
   bit            m_flush, m_ovr, m_fa, m_fb, m_mode_prev, e_slwr, e_pktend, e_slcs;
   logic [DW-1:0] e_fdata;

   slfifo_bus_driver_if #(.DATA_W(DW)) bus();

   slfifo_bus_driver #(.DATA_W(DW), .PKT_WORDS(PKT), .IDLE_TIMEOUT(TO), .FIFO_ADDR(2'b10)) dut (
      .clk_100(clk), .reset_(rst_n), .stream_in_mode_selected(mode), .slwr_in_(wr_n),
      .data_in(din), .flaga_d(flaga_d), .flagb_d(flagb_d), .word_cnt(word_cnt),
      .pkt_cnt(pkt_cnt), .overrun(overrun), .bus(bus)
   );

   always #5 clk = ~clk;

   // drive one cycle of inputs, advance the model, and land 1 time unit after the edge
   task automatic step(input bit m, input bit w, input logic [DW-1:0] d, input bit fa, input bit fb);
      bit fall, wrapped;
      int b0, i0;
      mode = m; wr_n = !w; din = d; bus.flaga = fa; bus.flagb = fb;
      if (!rst_n) begin
         m_buf = 0; m_pkts = 0; m_idle = 0; m_flush = 0; m_ovr = 0; m_fa = 0; m_fb = 0;
         m_mode_prev = 0; e_slwr = 1; e_pktend = 1; e_slcs = 1; e_fdata = '0;
      end else begin
         b0 = m_buf; i0 = m_idle; wrapped = 0;
         fall = !m && m_mode_prev;
         e_slwr = !w; e_slcs = !m; e_pktend = !m_flush;
         if (w) e_fdata = d;
         if (w && !m_fb) m_ovr = 1;
         if (m_flush) begin
            m_flush = 0; m_pkts++; m_buf = 0; m_idle = 0;
         end else begin
            if (w) begin
               m_buf++;
               if (m_buf == PKT) begin m_buf = 0; m_pkts++; wrapped = 1; end
            end
            m_idle = w ? 0 : (i0 < TO ? i0 + 1 : TO);
            if (b0 > 0 && !wrapped) begin
               if (fall && m_fb) m_flush = 1;
               else if (fall) begin m_buf = 0; m_ovr = 1; end
               else if (!w && i0 >= TO - 1 && m_fb) m_flush = 1;
            end
         end
         m_fa = fa; m_fb = fb; m_mode_prev = m;
      end
      @(posedge clk); #1; cyc++;
   endtask

   task automatic do_reset();
      rst_n = 0;
      repeat (2) step(0, 0, '0, 1, 1);
      rst_n = 1;
      step(1, 0, '0, 1, 1);
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) step(1, 1, $urandom, 1, 1);
      checks++;
      if ({bus.slwr_, bus.pktend_, bus.slcs_, bus.slrd_, bus.sloe_, flaga_d, flagb_d, overrun} !== 8'b11111000) begin
         errors++;
         $display("FAIL reset_ctl got %b want 11111000",
                  {bus.slwr_, bus.pktend_, bus.slcs_, bus.slrd_, bus.sloe_, flaga_d, flagb_d, overrun});
      end
      checks++;
      if (bus.fdata !== '0) begin errors++; $display("FAIL reset_fdata got %h want 0", bus.fdata); end
      checks++;
      if ({word_cnt, pkt_cnt} !== 32'd0) begin
         errors++; $display("FAIL reset_cnt got wc=%0d pc=%0d want 0/0", word_cnt, pkt_cnt);
      end
      checks++;
      if (bus.faddr !== 2'b10) begin errors++; $display("FAIL reset_faddr got %b want 10", bus.faddr); end
      rst_n = 1;
      step(1, 0, '0, 1, 1);
      checks++;
      if ({flaga_d, flagb_d} !== 2'b11) begin
         errors++; $display("FAIL flags_after_reset got %b want 11", {flaga_d, flagb_d});
      end
   endtask

   task automatic test_full_buffer();
      int pe_low = 0;
      do_reset();
      for (int i = 0; i < PKT; i++) begin
         step(1, 1, DW'(i), 1, 1);
         checks++;
         if (bus.slwr_ !== 1'b0 || bus.fdata !== DW'(i)) begin
            errors++; $display("FAIL burst_data i=%0d got slwr_=%b fdata=%0d want 0/%0d", i, bus.slwr_, bus.fdata, i);
         end
         if (bus.pktend_ !== 1'b1) pe_low++;
         if (i == PKT - 2) begin
            checks++;
            if (word_cnt !== 16'(PKT - 1)) begin
               errors++; $display("FAIL burst_wc_top got %0d want %0d", word_cnt, PKT - 1);
            end
         end
      end
      repeat (300) begin
         step(1, 0, '0, 1, 1);
         if (bus.pktend_ !== 1'b1) pe_low++;
      end
      checks++;
      if (word_cnt !== 16'd0 || pkt_cnt !== 16'd1) begin
         errors++; $display("FAIL burst_counts got wc=%0d pc=%0d want 0/1", word_cnt, pkt_cnt);
      end
      checks++;
      if (pe_low != 0) begin errors++; $display("FAIL burst_no_pktend got %0d low cycles want 0", pe_low); end
      checks++;
      if (bus.fdata !== DW'(PKT - 1) || bus.slwr_ !== 1'b1) begin
         errors++; $display("FAIL burst_hold got fdata=%0d slwr_=%b want %0d/1", bus.fdata, bus.slwr_, PKT - 1);
      end
   endtask

   task automatic test_timeout();
      int last = -1, first_pe = -1, pulses = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1, 1, $urandom, 1, 1);
         if (bus.slwr_ === 1'b0) last = cyc;
      end
      for (int k = 0; k < 400; k++) begin
         step(1, 0, '0, 1, 1);
         if (bus.pktend_ === 1'b0) begin pulses++; if (first_pe < 0) first_pe = cyc; end
         checks++;
         if (bus.pktend_ !== e_pktend) begin
            errors++; $display("FAIL timeout_model k=%0d got pktend_=%b want %b", k, bus.pktend_, e_pktend);
         end
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL timeout_pulses got %0d want 1", pulses); end
      checks++;
      if (first_pe - last != TO + 1) begin
         errors++; $display("FAIL timeout_delay got %0d want %0d", first_pe - last, TO + 1);
      end
      checks++;
      if (word_cnt !== 16'd0 || pkt_cnt !== 16'd1) begin
         errors++; $display("FAIL timeout_counts got wc=%0d pc=%0d want 0/1", word_cnt, pkt_cnt);
      end
   endtask

   task automatic test_flagb_defer();
      int last = -1, first_pe = -1, pulses = 0, low_while_blocked = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1, 1, $urandom, 1, 1);
         if (bus.slwr_ === 1'b0) last = cyc;
      end
      for (int k = 1; k <= 500; k++) begin
         step(1, 0, '0, 1, !(k >= 100 && k <= 400));
         if (bus.pktend_ === 1'b0) begin pulses++; if (first_pe < 0) first_pe = cyc; end
         if (bus.pktend_ === 1'b0 && flagb_d === 1'b0) low_while_blocked++;
      end
      checks++;
      if (pulses != 1 || low_while_blocked != 0) begin
         errors++; $display("FAIL defer_pulses got %0d (blocked %0d) want 1 (0)", pulses, low_while_blocked);
      end
      // flagb_d returns at idle cycle 401; flush is decided then and PKTEND lands two cycles on
      checks++;
      if (first_pe - last != 403) begin
         errors++; $display("FAIL defer_delay got %0d want 403", first_pe - last);
      end
      checks++;
      if ({overrun, word_cnt, pkt_cnt} !== {1'b0, 16'd0, 16'd1}) begin
         errors++; $display("FAIL defer_state got ovr=%b wc=%0d pc=%0d want 0/0/1", overrun, word_cnt, pkt_cnt);
      end
   endtask

   task automatic test_mode_exit();
      int pe_low = 0;
      do_reset();
      repeat (5) step(1, 1, $urandom, 1, 1);
      step(0, 0, '0, 1, 1);
      checks++;
      if (bus.slcs_ !== 1'b1 || bus.pktend_ !== 1'b1) begin
         errors++; $display("FAIL exit_deselect got slcs_=%b pktend_=%b want 1/1", bus.slcs_, bus.pktend_);
      end
      step(0, 0, '0, 1, 1);
      checks++;
      if ({bus.pktend_, word_cnt, pkt_cnt} !== {1'b0, 16'd0, 16'd1}) begin
         errors++; $display("FAIL exit_pktend got pktend_=%b wc=%0d pc=%0d want 0/0/1", bus.pktend_, word_cnt, pkt_cnt);
      end
      do_reset();
      repeat (5) step(1, 1, $urandom, 1, 1);
      repeat (3) step(1, 0, '0, 1, 0);
      checks++;
      if (overrun !== 1'b0 || word_cnt !== 16'd5) begin
         errors++; $display("FAIL exit_pre got ovr=%b wc=%0d want 0/5", overrun, word_cnt);
      end
      step(0, 0, '0, 1, 0);
      if (bus.pktend_ !== 1'b1) pe_low++;
      repeat (6) begin
         step(0, 0, '0, 1, 0);
         if (bus.pktend_ !== 1'b1) pe_low++;
      end
      checks++;
      if ({pe_low != 0, overrun, word_cnt, pkt_cnt} !== {1'b0, 1'b1, 16'd0, 16'd0}) begin
         errors++; $display("FAIL exit_overrun got pe_low=%0d ovr=%b wc=%0d pc=%0d want 0/1/0/0", pe_low, overrun, word_cnt, pkt_cnt);
      end
   endtask

   task automatic test_collisions();
      int l2 = -1, first_pe = -1, pulses = 0;
      logic [DW-1:0] x = $urandom;
      do_reset();
      repeat (3) step(1, 1, $urandom, 1, 1);
      repeat (TO - 1) begin
         step(1, 0, '0, 1, 1);
         if (bus.pktend_ === 1'b0) pulses++;
      end
      step(1, 1, $urandom, 1, 1);
      l2 = cyc;
      for (int k = 1; k <= 300; k++) begin
         step(1, 0, '0, 1, 1);
         if (bus.pktend_ === 1'b0) begin pulses++; if (first_pe < 0) first_pe = cyc; end
         if (k == 200) begin
            checks++;
            if (word_cnt !== 16'd4 || pulses != 0) begin
               errors++; $display("FAIL coincide_hold got wc=%0d pulses=%0d want 4/0", word_cnt, pulses);
            end
         end
      end
      checks++;
      if (pulses != 1 || first_pe - l2 != TO + 1) begin
         errors++; $display("FAIL coincide_restart got pulses=%0d delay=%0d want 1/%0d", pulses, first_pe - l2, TO + 1);
      end
      do_reset();
      repeat (3) step(1, 1, $urandom, 1, 1);
      repeat (TO) step(1, 0, '0, 1, 1);
      step(1, 1, x, 1, 1);
      checks++;
      if ({bus.slwr_, bus.pktend_, bus.fdata} !== {1'b0, 1'b0, x}) begin
         errors++; $display("FAIL flush_write got slwr_=%b pktend_=%b fdata=%h want 0/0/%h", bus.slwr_, bus.pktend_, bus.fdata, x);
      end
      step(1, 0, '0, 1, 1);
      checks++;
      if ({bus.pktend_, word_cnt, pkt_cnt} !== {1'b1, 16'd0, 16'd1}) begin
         errors++; $display("FAIL flush_write_after got pktend_=%b wc=%0d pc=%0d want 1/0/1", bus.pktend_, word_cnt, pkt_cnt);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int s = 0; s < 30; s++) begin
         int burst = $urandom_range(1, 80);
         int gap   = ($urandom_range(0, 2) == 0) ? $urandom_range(250, 300) : $urandom_range(0, 12);
         bit fb    = $urandom_range(0, 7) != 0;
         bit drop  = $urandom_range(0, 5) == 0;
         for (int c = 0; c < burst + gap; c++) begin
            bit w = c < burst && $urandom_range(0, 3) != 0;
            bit m = !(drop && c >= burst);
            step(m, w, $urandom, 1'($urandom_range(0, 1)), fb || $urandom_range(0, 3) != 0);
            checks++;
            if ({bus.slwr_, bus.pktend_, bus.slcs_, bus.slrd_, bus.sloe_, flaga_d, flagb_d, overrun,
                 word_cnt, pkt_cnt, bus.fdata, bus.faddr} !==
                {e_slwr, e_pktend, e_slcs, 1'b1, 1'b1, m_fa, m_fb, m_ovr,
                 16'(m_buf), 16'(m_pkts), e_fdata, 2'b10}) begin
               errors++;
               $display("FAIL random cyc=%0d got ctl=%b wc=%0d pc=%0d fdata=%h want ctl=%b wc=%0d pc=%0d fdata=%h",
                        cyc, {bus.slwr_, bus.pktend_, bus.slcs_, flaga_d, flagb_d, overrun}, word_cnt, pkt_cnt, bus.fdata,
                        {e_slwr, e_pktend, e_slcs, m_fa, m_fb, m_ovr}, m_buf, m_pkts, e_fdata);
            end
         end
      end
   endtask

   initial begin
      bus.flaga = 1; bus.flagb = 1;
      test_reset();
      test_full_buffer();
      test_timeout();
      test_flagb_defer();
      test_mode_exit();
      test_collisions();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/slfifo_bus_driver.md
# slfifo_bus_driver

Pad-side stage between the stream-in write generator and the FX3 Slave FIFO 2-bit-address bus. It registers the raw FX3 FLAGA/FLAGB pins into the `flaga_d`/`flagb_d` qualifiers the generator consumes. It re-registers the generator's write strobe and data onto the bus and drives the static control pins. It tracks words per DMA buffer and commits partial buffers with a one-cycle PKTEND after an idle timeout or on mode exit.

## Interface
- `DATA_W`, 32: FX3 data bus width.
- `PKT_WORDS`, 4096: words per FX3 DMA buffer; full buffers auto-commit with no PKTEND.
- `IDLE_TIMEOUT`, 256: idle cycles after the last write before a partial buffer is committed; must be ≥2.
- `FIFO_ADDR`, 2'b00: socket address driven on `faddr`.

Ports:
- `clk_100` in 1: sole clock (100 MHz, also forwarded to the FX3 PCLK pin externally).
- `reset_` in 1: synchronous, active-low reset.
- `stream_in_mode_selected` in 1: stream-in mode enable.
- `slwr_in_` in 1: active-low write strobe from the generator.
- `data_in` in DATA_W: write data from the generator, valid when `slwr_in_`=0.
- `flaga` in 1: raw FX3 FLAGA pin (DMA ready).
- `flagb` in 1: raw FX3 FLAGB pin (watermark; 1 = room to write).
- `flaga_d`, `flagb_d` out 1: registered flags to the generator.
- `fdata` out DATA_W: bus data.
- `faddr` out 2: constant `FIFO_ADDR`.
- `slcs_`, `slwr_`, `slrd_`, `sloe_`, `pktend_` out 1: active-low bus controls.
- `word_cnt` out 16: words in the current buffer, range 0..PKT_WORDS-1.
- `pkt_cnt` out 16: committed buffers, wraps modulo 2^16.
- `overrun` out 1: sticky error flag.

## Operation
- Flags: `flaga_d`/`flagb_d` take one flop each from the pins, with no further synchronisation because the domain is shared with PCLK.
- Write path: each cycle `slwr_` takes `slwr_in_` and `fdata` takes `data_in` when `slwr_in_`=0. Otherwise `fdata` holds.
- Static controls: `slrd_`=1 and `sloe_`=1 always, since this stage is write only. `slcs_` is the registered inverse of `stream_in_mode_selected`.
- Word counter: increments on each accepted write (`slwr_in_`=0).
  - At PKT_WORDS-1 a write wraps it to 0 and increments `pkt_cnt`.
- Idle counter: resets to 0 on any write; otherwise increments, saturating at IDLE_TIMEOUT.
- FSM states:
  - IDLE: `word_cnt`=0. Goes to FILL on a write that leaves `word_cnt`≠0.
  - FILL: partial buffer in progress.
    - Goes to IDLE when a write wraps `word_cnt` to 0.
    - Goes to FLUSH when idle counter = IDLE_TIMEOUT-1, no write this cycle, and `flagb_d`=1.
    - Goes to FLUSH when `stream_in_mode_selected` falls and `flagb_d`=1.
    - If mode falls with `flagb_d`=0: go to IDLE, clear `word_cnt`, set `overrun`, no PKTEND.
  - FLUSH, 1 cycle: registered `pktend_`=0 and `slwr_`=1 on the next bus cycle. `pkt_cnt`+1, `word_cnt` and idle counter go to 0, then IDLE.
- Simultaneous events:
  - A write in the same cycle the timeout would fire wins. No FLUSH; the idle counter restarts.
  - A write arriving during FLUSH is forwarded in the same bus cycle as PKTEND (FX3 treats it as the last word). It does not advance `word_cnt`, which still clears.
- `overrun` also sets on `slwr_in_`=0 while `flagb_d`=0. It clears only on reset.
- Reset mid-packet: the partial buffer is abandoned with no PKTEND; all counters clear.

## Timing
- Reset values: `slwr_`=1, `pktend_`=1, `slcs_`=1, `slrd_`=1, `sloe_`=1, `fdata`=0, `faddr`=`FIFO_ADDR`, `flaga_d`=`flagb_d`=0, `word_cnt`=`pkt_cnt`=0, `overrun`=0, FSM=IDLE, idle counter=0.
- Pin to `flagX_d` latency: 1 cycle.
- Latency from `slwr_in_`/`data_in` to `slwr_`/`fdata`: 1 cycle, both aligned in the same bus cycle.
- PKTEND on a timeout: `pktend_` falls exactly IDLE_TIMEOUT+1 cycles after the last `slwr_` low bus cycle, given `flagb_d`=1. It lasts exactly 1 cycle.
- While `flagb_d`=0, the timeout FLUSH is deferred and the idle counter holds saturated. FLUSH fires the first cycle `flagb_d` is 1.
- All outputs are registered; there are no combinational pin-to-pin paths.

## Test plan
- Reset with `flaga`=`flagb`=1 held → all outputs at reset values, then `flaga_d`=`flagb_d`=1 one cycle after `reset_` rises.
- Burst of 4096 writes with data 0..4095 → `fdata` is 0..4095 one cycle delayed, `word_cnt` wraps to 0, `pkt_cnt`=1, `pktend_` never low.
- 10 writes then idle, IDLE_TIMEOUT=256 → a single `pktend_` low pulse 257 cycles after the last bus write, `pkt_cnt`=1, `word_cnt`=0.
- 10 writes, idle, `flagb` low from idle cycle 100 to 400 → no PKTEND while `flagb_d`=0, pulse on the first cycle `flagb_d`=1.
- 5 writes then mode deselected with `flagb`=1 → PKTEND next cycle, `slcs_`=1. Repeat with `flagb`=0 → no PKTEND, `overrun`=1, `word_cnt`=0.
- Write coincident with the timeout cycle and write during FLUSH → no PKTEND in the first case; the second forwards the data word with `pktend_`=0 in the same bus cycle.
